// File: rtl/patch_pkg.sv
// Shared types and default geometry for the image-path blocks.
// The geometry constants here are defaults; modules take their own parameters.
package patch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_CHANNEL_SIZE = 8;
  localparam int DEF_NUM_CHANNELS = 3;
  localparam int DEF_PIXEL_WIDTH  = DEF_CHANNEL_SIZE * DEF_NUM_CHANNELS;
  localparam int DEF_IMG_WIDTH    = 64;
  localparam int DEF_IMG_HEIGHT   = 64;
  localparam int DEF_PATCH_SIZE   = 16;

  typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;

  // Counter width that stays legal when a dimension collapses to a single step.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unpatchifier_if.sv
// Pixel stream handshake into the unpatchifier.
interface unpatchifier_if #(
  parameter int PIXEL_WIDTH = patch_pkg::DEF_PIXEL_WIDTH
) ();
  logic                   pix_valid;
  logic [PIXEL_WIDTH-1:0] pix_data;
  logic                   pix_ready;

  modport master (output pix_valid, output pix_data, input pix_ready);
  modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/patch_addr_gen.sv
// Cascaded position/patch counters turning a patch-major pixel stream
// into row/column write addresses without any division.
module patch_addr_gen
  import patch_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int PATCH_SIZE = DEF_PATCH_SIZE,
  parameter int ROW_W      = cnt_width(IMG_HEIGHT),
  parameter int COL_W      = cnt_width(IMG_WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam int PATCHES_IN_ROW = IMG_WIDTH / PATCH_SIZE;
  localparam int PATCHES_IN_COL = IMG_HEIGHT / PATCH_SIZE;
  localparam int POS_W = cnt_width(PATCH_SIZE);
  localparam int PC_W  = cnt_width(PATCHES_IN_ROW);
  localparam int PR_W  = cnt_width(PATCHES_IN_COL);

  logic [POS_W-1:0] pos_col_q, pos_col_d;
  logic [POS_W-1:0] pos_row_q, pos_row_d;
  logic [PC_W-1:0]  patch_col_q, patch_col_d;
  logic [PR_W-1:0]  patch_row_q, patch_row_d;

  logic pos_col_wrap, pos_row_wrap, patch_col_wrap, patch_row_wrap;

  assign pos_col_wrap   = (pos_col_q   == POS_W'(PATCH_SIZE - 1));
  assign pos_row_wrap   = (pos_row_q   == POS_W'(PATCH_SIZE - 1));
  assign patch_col_wrap = (patch_col_q == PC_W'(PATCHES_IN_ROW - 1));
  assign patch_row_wrap = (patch_row_q == PR_W'(PATCHES_IN_COL - 1));

  always_comb begin
    pos_col_d   = pos_col_q;
    pos_row_d   = pos_row_q;
    patch_col_d = patch_col_q;
    patch_row_d = patch_row_q;
    if (clear) begin
      pos_col_d   = '0;
      pos_row_d   = '0;
      patch_col_d = '0;
      patch_row_d = '0;
    end else if (advance) begin
      // Each counter only moves when every faster counter below it wraps.
      if (pos_col_wrap) begin
        pos_col_d = '0;
        if (pos_row_wrap) begin
          pos_row_d = '0;
          if (patch_col_wrap) begin
            patch_col_d = '0;
            patch_row_d = patch_row_wrap ? '0 : patch_row_q + 1'b1;
          end else begin
            patch_col_d = patch_col_q + 1'b1;
          end
        end else begin
          pos_row_d = pos_row_q + 1'b1;
        end
      end else begin
        pos_col_d = pos_col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_col_q   <= '0;
      pos_row_q   <= '0;
      patch_col_q <= '0;
      patch_row_q <= '0;
    end else begin
      pos_col_q   <= pos_col_d;
      pos_row_q   <= pos_row_d;
      patch_col_q <= patch_col_d;
      patch_row_q <= patch_row_d;
    end
  end

  assign row  = ROW_W'(int'(patch_row_q) * PATCH_SIZE + int'(pos_row_q));
  assign col  = COL_W'(int'(patch_col_q) * PATCH_SIZE + int'(pos_col_q));
  assign last = pos_col_wrap && pos_row_wrap && patch_col_wrap && patch_row_wrap;

endmodule

// File: rtl/unpatchifier.sv
// Reassembles patch-major pixel vectors into a row-major image register array,
// held until the consumer releases it with output_taken.
module unpatchifier
  import patch_pkg::*;
#(
  parameter int CHANNEL_SIZE = DEF_CHANNEL_SIZE,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int PIXEL_WIDTH  = CHANNEL_SIZE * NUM_CHANNELS,
  parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int PATCH_SIZE   = DEF_PATCH_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        output_taken,
  unpatchifier_if.slave pix_if,
  output logic [1:0]  state,
  output logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][PIXEL_WIDTH-1:0] image_out
);

  localparam int ROW_W = cnt_width(IMG_HEIGHT);
  localparam int COL_W = cnt_width(IMG_WIDTH);

  state_t state_q, state_d;
  logic   clear_cnt, clear_img, xfer, last;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [IMG_HEIGHT-1:0][IMG_WIDTH-1:0][PIXEL_WIDTH-1:0] image_q, image_d;

  assign pix_if.pix_ready = (state_q == LOAD);
  assign xfer             = pix_if.pix_valid && pix_if.pix_ready;

  always_comb begin
    state_d   = state_q;
    clear_cnt = 1'b0;
    clear_img = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = LOAD;
          clear_cnt = 1'b1;
        end
      end
      LOAD: begin
        if (xfer && last) state_d = DONE;
      end
      DONE: begin
        if (output_taken) begin
          state_d   = IDLE;
          clear_img = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    image_d = image_q;
    if (clear_img) begin
      image_d = '0;
    end else if (xfer) begin
      image_d[row][col] = pix_if.pix_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      image_q <= '0;
    end else begin
      state_q <= state_d;
      image_q <= image_d;
    end
  end

  patch_addr_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .PATCH_SIZE (PATCH_SIZE),
    .ROW_W      (ROW_W),
    .COL_W      (COL_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_cnt),
    .advance (xfer),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  assign state     = state_q;
  assign image_out = image_q;

endmodule

// File: tb/tb_unpatchifier.sv
// Randomised bench for the unpatchifier: a default 64x64 instance and a small 8x8 one,
// checked against a division-based placement model.
module tb_unpatchifier;

  localparam int PW    = 24;
  localparam int W     = 64;
  localparam int H     = 64;
  localparam int PS    = 16;
  localparam int PIR   = W / PS;
  localparam int NPIX  = W * H;
  localparam int SW    = 8;
  localparam int SPS   = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0, ot = 1'b0;
  logic en_s = 1'b0, ot_s = 1'b0;
  logic [1:0] state, state_s;
  logic [H-1:0][W-1:0][PW-1:0]   image;
  logic [SW-1:0][SW-1:0][PW-1:0] image_s;

  logic [PW-1:0] exp_img [H][W];
  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  unpatchifier_if #(.PIXEL_WIDTH(PW)) big_if ();
  unpatchifier_if #(.PIXEL_WIDTH(PW)) small_if ();

  unpatchifier #(
    .CHANNEL_SIZE(8), .NUM_CHANNELS(3), .PIXEL_WIDTH(PW),
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PATCH_SIZE(PS)
  ) u_dut (
    .clk(clk), .reset(reset), .en(en), .output_taken(ot),
    .pix_if(big_if), .state(state), .image_out(image)
  );

  unpatchifier #(
    .CHANNEL_SIZE(8), .NUM_CHANNELS(3), .PIXEL_WIDTH(PW),
    .IMG_WIDTH(SW), .IMG_HEIGHT(SW), .PATCH_SIZE(SPS)
  ) u_small (
    .clk(clk), .reset(reset), .en(en_s), .output_taken(ot_s),
    .pix_if(small_if), .state(state_s), .image_out(image_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic clear_model();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_img[r][c] = '0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL start_load state=%b expected=01", state);
    end
    $display("start frame: state=%b", state);
  endtask

  // Streams n_pix handshakes; the model places each accepted pixel by division.
  task automatic stream(input bit use_k, input int gap_pct, input int n_pix);
    int idx = 0;
    int guard = 0;
    int not_load = 0;
    bit v, hs;
    logic [PW-1:0] d;
    while (idx < n_pix && guard < 20000) begin
      @(negedge clk);
      if (state !== 2'b01) not_load++;
      v = ($urandom_range(99) >= gap_pct);
      d = use_k ? PW'(idx) : PW'($urandom);
      big_if.pix_valid = v;
      big_if.pix_data  = d;
      hs = v && big_if.pix_ready;
      if (hs) exp_img[(idx / (PS * PS) / PIR) * PS + (idx % (PS * PS)) / PS]
                     [(idx / (PS * PS) % PIR) * PS + idx % PS] = d;
      @(posedge clk);
      if (hs) idx++;
      guard++;
    end
    checks++;
    if (idx != n_pix || not_load != 0) begin
      failures++;
      $display("FAIL stream accepted=%0d expected=%0d non_load_cycles=%0d", idx, n_pix, not_load);
    end
    $display("stream: accepted=%0d cycles=%0d gap=%0d", idx, guard, gap_pct);
  endtask

  task automatic compare_img(input string name);
    int bad = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (image[r][c] !== exp_img[r][c]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s mismatching_pixels=%0d expected=0", name, bad);
    end
    $display("compare %s: bad=%0d", name, bad);
  endtask

  task automatic check_k_formula(input string name);
    int bad = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (image[r][c] !== PW'(((r / 16) * 4 + c / 16) * 256 + (r % 16) * 16 + c % 16)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s formula_mismatches=%0d expected=0", name, bad);
    end
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if (state !== 2'b00 || image !== '0) begin
      failures++;
      $display("FAIL %s state=%b image_zero=%0d expected state=00 image_zero=1",
               name, state, image == '0);
    end
    $display("%s: state=%b", name, state);
  endtask

  task automatic release_frame();
    @(negedge clk);
    ot = 1'b1;
    @(posedge clk);
    #1;
    ot = 1'b0;
    check_cleared("release");
  endtask

  task automatic test_reset();
    reset = 1'b0;
    big_if.pix_valid = 1'b0;
    big_if.pix_data = '0;
    small_if.pix_valid = 1'b0;
    small_if.pix_data = '0;
    #3;
    check_cleared("reset_big");
    checks++;
    if (big_if.pix_ready !== 1'b0 || state_s !== 2'b00 || image_s !== '0) begin
      failures++;
      $display("FAIL reset_misc ready=%b small_state=%b expected ready=0 small_state=00",
               big_if.pix_ready, state_s);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL reset_release state=%b expected=00", state);
    end
  endtask

  task automatic test_single_frame();
    int start;
    clear_model();
    start_frame();
    start = cyc_cnt;
    stream(1'b1, 0, NPIX);
    #1;
    checks++;
    if (state !== 2'b10 || (cyc_cnt - start + 1) != NPIX + 1) begin
      failures++;
      $display("FAIL frame_latency state=%b cycles=%0d expected state=10 cycles=%0d",
               state, cyc_cnt - start + 1, NPIX + 1);
    end
    compare_img("single_frame");
    check_k_formula("single_frame");
    checks++;
    if (image[31][47] !== PW'(1791)) begin
      failures++;
      $display("FAIL pix_31_47 got=%0d expected=1791", image[31][47]);
    end
  endtask

  task automatic test_valid_after_last();
    int ready_hi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      big_if.pix_valid = 1'b1;
      big_if.pix_data  = PW'($urandom);
      if (big_if.pix_ready !== 1'b0) ready_hi++;
    end
    #1;
    checks++;
    if (ready_hi != 0 || state !== 2'b10 || image[63][63] !== PW'(4095)) begin
      failures++;
      $display("FAIL hold_after_last ready_hi=%0d state=%b px=%0d expected 0/10/4095",
               ready_hi, state, image[63][63]);
    end
    compare_img("hold_after_last");
    big_if.pix_valid = 1'b0;
  endtask

  task automatic test_taken_with_en();
    @(negedge clk);
    en = 1'b1;
    ot = 1'b1;
    @(posedge clk);
    #1;
    check_cleared("taken_with_en");
    @(negedge clk);
    ot = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b0;
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL en_after_idle state=%b expected=01", state);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_gaps();
    clear_model();
    start_frame();
    stream(1'b0, 30, NPIX);
    #1;
    checks++;
    if (state !== 2'b10) begin
      failures++;
      $display("FAIL gaps_done state=%b expected=10", state);
    end
    big_if.pix_valid = 1'b0;
    compare_img("gaps");
    release_frame();
  endtask

  task automatic test_mid_reset();
    clear_model();
    start_frame();
    stream(1'b1, 0, 1000);
    #2;
    reset = 1'b0;
    #1;
    check_cleared("mid_reset_async");
    big_if.pix_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    start_frame();
    stream(1'b1, 0, NPIX);
    #1;
    big_if.pix_valid = 1'b0;
    checks++;
    if (state !== 2'b10) begin
      failures++;
      $display("FAIL after_reset_done state=%b expected=10", state);
    end
    compare_img("after_reset");
    check_k_formula("after_reset");
    release_frame();
  endtask

  task automatic test_small();
    int idx = 0;
    int guard = 0;
    int bad = 0;
    bit hs;
    @(negedge clk);
    en_s = 1'b1;
    @(posedge clk);
    #1;
    en_s = 1'b0;
    while (idx < SW * SW && guard < 1000) begin
      @(negedge clk);
      small_if.pix_valid = ($urandom_range(99) >= 20);
      small_if.pix_data  = PW'(idx);
      hs = small_if.pix_valid && small_if.pix_ready;
      @(posedge clk);
      if (hs) idx++;
      guard++;
    end
    #1;
    small_if.pix_valid = 1'b0;
    for (int r = 0; r < SW; r++)
      for (int c = 0; c < SW; c++)
        if (image_s[r][c] !== PW'(((r / 4) * 2 + c / 4) * 16 + (r % 4) * 4 + c % 4)) bad++;
    checks++;
    if (state_s !== 2'b10 || bad != 0) begin
      failures++;
      $display("FAIL small_frame state=%b bad=%0d expected state=10 bad=0", state_s, bad);
    end
    checks++;
    if (image_s[5][2] !== PW'(38)) begin
      failures++;
      $display("FAIL small_5_2 got=%0d expected=38", image_s[5][2]);
    end
    $display("small frame: accepted=%0d px52=%0d", idx, image_s[5][2]);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_valid_after_last();
    test_taken_with_en();
    test_gaps();
    test_mid_reset();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
